// File: rtl/mem_access_stage.sv
// Memory-access stage of the RV32I core: byte/half/word loads and stores over a
// req/ack data bus with wait states, upstream stall, and the MEM/WB register.
module mem_access_stage #(
   parameter int TIMEOUT = 16,
   parameter int CNT_W   = 5
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [31:0] EX_MEM_ALU_OUT,
   input  logic [31:0] EX_MEM_writedata,
   input  logic        EX_MEM_memwrite_en,
   input  logic        EX_MEM_regwrite_en,
   input  logic        EX_MEM_wb_sel,
   input  logic [4:0]  EX_MEM_RD,
   input  logic [2:0]  EX_MEM_funct3,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [3:0]  dmem_be,
   output logic [31:0] dmem_wdata,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ack,
   output logic        mem_stall,
   output logic [31:0] MEM_WB_result,
   output logic [4:0]  MEM_WB_RD,
   output logic        MEM_WB_regwrite_en,
   output logic        misalign_err,
   output logic        bus_err
);
   // state | meaning
   // IDLE  | pass ALU results through, check and latch new memory ops
   // BUSY  | bus request outstanding, waiting for dmem_ack or timeout
   localparam logic [0:0] IDLE = 1'b0;
   localparam logic [0:0] BUSY = 1'b1;

   logic [0:0]       state;
   logic [CNT_W-1:0] cnt;
   logic [31:0]      addr_q;
   logic [31:0]      wdata_q;
   logic [3:0]       be_q;
   logic             we_q;
   logic [2:0]       funct3_q;
   logic [4:0]       rd_q;
   logic             regwrite_q;
   logic             wb_sel_q;

   logic        mem_op;
   logic        illegal;
   logic        misaligned;
   logic        timeout;
   logic [3:0]  be_n;
   logic [31:0] wdata_n;
   logic [7:0]  byte_sel;
   logic [15:0] half_sel;
   logic [31:0] load_data;

   assign mem_op     = EX_MEM_memwrite_en | EX_MEM_wb_sel;
   assign illegal    = (EX_MEM_funct3 == 3'b011) || (EX_MEM_funct3 == 3'b110) ||
                       (EX_MEM_funct3 == 3'b111);
   assign misaligned = ((EX_MEM_funct3[1:0] == 2'b01) && EX_MEM_ALU_OUT[0]) ||
                       ((EX_MEM_funct3 == 3'b010) && (EX_MEM_ALU_OUT[1:0] != 2'b00));
   assign timeout    = (state == BUSY) && !dmem_ack && (cnt == CNT_W'(TIMEOUT - 1));

   assign dmem_req   = (state == BUSY);
   assign dmem_we    = we_q;
   assign dmem_addr  = {addr_q[31:2], 2'b00};
   assign dmem_be    = be_q;
   assign dmem_wdata = wdata_q;

   always_comb begin
      if (state == IDLE) mem_stall = mem_op && !illegal && !misaligned;
      else               mem_stall = !dmem_ack && !timeout;
   end

   // loads always read the whole word; lane selection happens on the way back
   always_comb begin
      be_n    = 4'b1111;
      wdata_n = EX_MEM_writedata;
      if (EX_MEM_memwrite_en) begin
         case (EX_MEM_funct3[1:0])
            2'b00: begin
               be_n    = 4'b0001 << EX_MEM_ALU_OUT[1:0];
               wdata_n = {4{EX_MEM_writedata[7:0]}};
            end
            2'b01: begin
               be_n    = EX_MEM_ALU_OUT[1] ? 4'b1100 : 4'b0011;
               wdata_n = {2{EX_MEM_writedata[15:0]}};
            end
            default: ;
         endcase
      end
   end

   assign byte_sel = dmem_rdata[{addr_q[1:0], 3'b000} +: 8];
   assign half_sel = addr_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];

   always_comb begin
      case (funct3_q)
         3'b000:  load_data = {{24{byte_sel[7]}}, byte_sel};
         3'b001:  load_data = {{16{half_sel[15]}}, half_sel};
         3'b100:  load_data = {24'h0, byte_sel};
         3'b101:  load_data = {16'h0, half_sel};
         default: load_data = dmem_rdata;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state              <= IDLE;
         cnt                <= '0;
         addr_q             <= '0;
         wdata_q            <= '0;
         be_q               <= '0;
         we_q               <= 1'b0;
         funct3_q           <= '0;
         rd_q               <= '0;
         regwrite_q         <= 1'b0;
         wb_sel_q           <= 1'b0;
         MEM_WB_result      <= '0;
         MEM_WB_RD          <= '0;
         MEM_WB_regwrite_en <= 1'b0;
         misalign_err       <= 1'b0;
         bus_err            <= 1'b0;
      end else begin
         misalign_err <= 1'b0;
         bus_err      <= 1'b0;
         case (state)
            IDLE: begin
               if (!mem_op) begin
                  MEM_WB_result      <= EX_MEM_ALU_OUT;
                  MEM_WB_RD          <= EX_MEM_RD;
                  MEM_WB_regwrite_en <= EX_MEM_regwrite_en;
               end else if (illegal || misaligned) begin
                  MEM_WB_regwrite_en <= 1'b0;
                  misalign_err       <= 1'b1;
               end else begin
                  addr_q             <= EX_MEM_ALU_OUT;
                  wdata_q            <= wdata_n;
                  be_q               <= be_n;
                  we_q               <= EX_MEM_memwrite_en;
                  funct3_q           <= EX_MEM_funct3;
                  rd_q               <= EX_MEM_RD;
                  regwrite_q         <= EX_MEM_regwrite_en;
                  wb_sel_q           <= EX_MEM_wb_sel;
                  MEM_WB_regwrite_en <= 1'b0;
                  cnt                <= '0;
                  state              <= BUSY;
               end
            end
            BUSY: begin
               if (dmem_ack) begin
                  MEM_WB_result      <= wb_sel_q ? load_data : addr_q;
                  MEM_WB_RD          <= rd_q;
                  MEM_WB_regwrite_en <= regwrite_q;
                  state              <= IDLE;
               end else if (timeout) begin
                  bus_err            <= 1'b1;
                  MEM_WB_regwrite_en <= 1'b0;
                  state              <= IDLE;
               end else begin
                  cnt <= cnt + 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: table of single-cycle ALU/illegal ops plus
// hand-written bus sequences for wait states, timeout and mid-transaction reset.
module tb_mem_access_stage;
   logic        clk = 1'b0;
   logic        rst;
   logic [31:0] alu_out, writedata;
   logic        memwrite_en, regwrite_en, wb_sel;
   logic [4:0]  rd;
   logic [2:0]  funct3;
   logic        dmem_req, dmem_we, dmem_ack;
   logic [31:0] dmem_addr, dmem_wdata, dmem_rdata;
   logic [3:0]  dmem_be;
   logic        mem_stall;
   logic [31:0] wb_result;
   logic [4:0]  wb_rd;
   logic        wb_regwrite, misalign_err, bus_err;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.TIMEOUT(16), .CNT_W(5)) dut (
      .clk(clk), .rst(rst),
      .EX_MEM_ALU_OUT(alu_out), .EX_MEM_writedata(writedata),
      .EX_MEM_memwrite_en(memwrite_en), .EX_MEM_regwrite_en(regwrite_en),
      .EX_MEM_wb_sel(wb_sel), .EX_MEM_RD(rd), .EX_MEM_funct3(funct3),
      .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_addr(dmem_addr),
      .dmem_be(dmem_be), .dmem_wdata(dmem_wdata), .dmem_rdata(dmem_rdata),
      .dmem_ack(dmem_ack), .mem_stall(mem_stall),
      .MEM_WB_result(wb_result), .MEM_WB_RD(wb_rd),
      .MEM_WB_regwrite_en(wb_regwrite), .misalign_err(misalign_err),
      .bus_err(bus_err)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   task automatic chk1(input string name, input logic act, input logic exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %b expected %b", name, act, exp);
      end
   endtask

   task automatic drive(input logic [31:0] a, input logic [31:0] wd, input logic mw,
                        input logic rw, input logic ws, input logic [4:0] r,
                        input logic [2:0] f3);
      alu_out = a; writedata = wd; memwrite_en = mw; regwrite_en = rw;
      wb_sel = ws; rd = r; funct3 = f3;
   endtask

   task automatic drive_nop();
      drive(32'h0, 32'h0, 1'b0, 1'b0, 1'b0, 5'd0, 3'b010);
   endtask

   // Called at posedge+1 with the stage idle; ack arrives in BUSY cycle d.
   task automatic mem_seq(input string name, input logic [31:0] a, input logic [31:0] wd,
                          input logic mw, input logic rw, input logic ws,
                          input logic [4:0] r, input logic [2:0] f3, input int d,
                          input logic [31:0] rdata, input logic [31:0] e_addr,
                          input logic [3:0] e_be, input logic [31:0] e_wdata,
                          input logic chk_wd, input logic [31:0] e_res);
      int stalls;
      int reqs;
      drive(a, wd, mw, rw, ws, r, f3);
      dmem_ack = 1'b0;
      #1;
      stalls = mem_stall ? 1 : 0;
      reqs   = 0;
      chk1({name, "_req_idle"}, dmem_req, 1'b0);
      @(posedge clk); #1;
      for (int c = 0; c <= d; c++) begin
         if (c == d) begin
            dmem_ack   = 1'b1;
            dmem_rdata = rdata;
         end
         #1;
         if (dmem_req) reqs++;
         if (mem_stall) stalls++;
         chk1({name, "_we"}, dmem_we, mw);
         chk({name, "_addr"}, dmem_addr, e_addr);
         chk({name, "_be"}, {28'h0, dmem_be}, {28'h0, e_be});
         if (chk_wd) chk({name, "_wdata"}, dmem_wdata, e_wdata);
         @(posedge clk); #1;
         dmem_ack   = 1'b0;
         dmem_rdata = 32'h0;
      end
      drive_nop();
      chk({name, "_req_cycles"}, 32'(reqs), 32'(d + 1));
      chk({name, "_stall_cycles"}, 32'(stalls), 32'(d + 1));
      chk1({name, "_req_done"}, dmem_req, 1'b0);
      chk({name, "_result"}, wb_result, e_res);
      chk({name, "_rd"}, {27'h0, wb_rd}, {27'h0, r});
      chk1({name, "_regwrite"}, wb_regwrite, rw);
   endtask

   typedef struct {
      logic [31:0] a;
      logic        mw, rw, ws;
      logic [4:0]  r;
      logic [2:0]  f3;
      logic [31:0] e_res;
      logic [4:0]  e_rd;
      logic        e_rw, e_err;
   } vec_t;

   vec_t vecs[10];
   int   reqs;

   initial begin
      vecs[0] = '{32'h0000_1234, 1'b0, 1'b1, 1'b0, 5'd5,  3'b000, 32'h0000_1234, 5'd5,  1'b1, 1'b0};
      vecs[1] = '{32'h0000_0101, 1'b0, 1'b1, 1'b1, 5'd7,  3'b010, 32'h0,         5'd0,  1'b0, 1'b1};
      vecs[2] = '{32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 5'd31, 3'b010, 32'hDEAD_BEEF, 5'd31, 1'b1, 1'b0};
      vecs[3] = '{32'h0000_0100, 1'b0, 1'b1, 1'b1, 5'd8,  3'b111, 32'h0,         5'd0,  1'b0, 1'b1};
      vecs[4] = '{32'h0000_0103, 1'b1, 1'b0, 1'b0, 5'd0,  3'b001, 32'h0,         5'd0,  1'b0, 1'b1};
      vecs[5] = '{32'h0000_0000, 1'b0, 1'b0, 1'b0, 5'd0,  3'b000, 32'h0,         5'd0,  1'b0, 1'b0};
      vecs[6] = '{32'h0000_0102, 1'b1, 1'b0, 1'b0, 5'd0,  3'b010, 32'h0,         5'd0,  1'b0, 1'b1};
      vecs[7] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd2,  3'b011, 32'h0,         5'd0,  1'b0, 1'b1};
      vecs[8] = '{32'h0000_0000, 1'b0, 1'b1, 1'b1, 5'd2,  3'b110, 32'h0,         5'd0,  1'b0, 1'b1};
      vecs[9] = '{32'h0000_A5A5, 1'b0, 1'b1, 1'b0, 5'd1,  3'b111, 32'h0000_A5A5, 5'd1,  1'b1, 1'b0};

      rst = 1'b1;
      drive_nop();
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;
      repeat (2) @(posedge clk);
      #1;
      chk1("rst_req", dmem_req, 1'b0);
      chk1("rst_stall", mem_stall, 1'b0);
      chk("rst_result", wb_result, 32'h0);
      chk1("rst_regwrite", wb_regwrite, 1'b0);
      chk1("rst_misalign", misalign_err, 1'b0);
      chk1("rst_bus_err", bus_err, 1'b0);
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;

      // stray acks while idle must not disturb the pass-through path
      dmem_ack   = 1'b1;
      dmem_rdata = 32'hBAD0_BAD0;
      for (int i = 0; i < 10; i++) begin
         drive(vecs[i].a, 32'h0, vecs[i].mw, vecs[i].rw, vecs[i].ws, vecs[i].r, vecs[i].f3);
         #1;
         chk1("vec_stall", mem_stall, 1'b0);
         @(posedge clk); #1;
         chk1("vec_req", dmem_req, 1'b0);
         chk1("vec_regwrite", wb_regwrite, vecs[i].e_rw);
         chk1("vec_misalign", misalign_err, vecs[i].e_err);
         if (!vecs[i].e_err) begin
            chk("vec_result", wb_result, vecs[i].e_res);
            chk("vec_rd", {27'h0, wb_rd}, {27'h0, vecs[i].e_rd});
         end
      end
      dmem_ack   = 1'b0;
      dmem_rdata = 32'h0;

      mem_seq("lb",  32'h103, 32'h0, 1'b0, 1'b1, 1'b1, 5'd10, 3'b000, 3, 32'h80FF_0000,
              32'h100, 4'hF, 32'h0, 1'b0, 32'hFFFF_FF80);
      mem_seq("lbu", 32'h103, 32'h0, 1'b0, 1'b1, 1'b1, 5'd11, 3'b100, 3, 32'h80FF_0000,
              32'h100, 4'hF, 32'h0, 1'b0, 32'h0000_0080);
      mem_seq("sh",  32'h202, 32'h0000_ABCD, 1'b1, 1'b0, 1'b0, 5'd0, 3'b001, 0, 32'h0,
              32'h200, 4'b1100, 32'hABCD_ABCD, 1'b1, 32'h202);
      mem_seq("lh",  32'h102, 32'h0, 1'b0, 1'b1, 1'b1, 5'd12, 3'b001, 1, 32'hF00D_5678,
              32'h100, 4'hF, 32'h0, 1'b0, 32'hFFFF_F00D);
      mem_seq("lhu", 32'h100, 32'h0, 1'b0, 1'b1, 1'b1, 5'd13, 3'b101, 2, 32'h1234_8001,
              32'h100, 4'hF, 32'h0, 1'b0, 32'h0000_8001);
      mem_seq("lw",  32'h104, 32'h0, 1'b0, 1'b1, 1'b1, 5'd9, 3'b010, 0, 32'hCAFE_BABE,
              32'h104, 4'hF, 32'h0, 1'b0, 32'hCAFE_BABE);
      mem_seq("sb",  32'h301, 32'h1234_5678, 1'b1, 1'b0, 1'b0, 5'd0, 3'b000, 2, 32'h0,
              32'h300, 4'b0010, 32'h7878_7878, 1'b1, 32'h301);

      // timeout: ack never arrives
      drive(32'h500, 32'h0, 1'b0, 1'b1, 1'b1, 5'd4, 3'b010);
      #1;
      chk1("to_stall_idle", mem_stall, 1'b1);
      @(posedge clk); #1;
      reqs = 0;
      for (int c = 0; c < 16; c++) begin
         if (dmem_req) reqs++;
         chk1("to_stall", mem_stall, (c == 15) ? 1'b0 : 1'b1);
         @(posedge clk); #1;
      end
      drive(32'h77, 32'h0, 1'b0, 1'b1, 1'b0, 5'd3, 3'b010);
      chk("to_req_cycles", 32'(reqs), 32'd16);
      chk1("to_req_done", dmem_req, 1'b0);
      chk1("to_bus_err", bus_err, 1'b1);
      chk1("to_regwrite", wb_regwrite, 1'b0);
      #1;
      chk1("to_stall_after", mem_stall, 1'b0);
      @(posedge clk); #1;
      chk1("to_bus_err_clear", bus_err, 1'b0);
      chk("to_next_result", wb_result, 32'h77);
      chk("to_next_rd", {27'h0, wb_rd}, 32'd3);
      chk1("to_next_regwrite", wb_regwrite, 1'b1);

      // asynchronous reset in the third BUSY cycle
      drive(32'h80, 32'h0, 1'b0, 1'b1, 1'b1, 5'd6, 3'b010);
      repeat (3) begin
         @(posedge clk); #1;
      end
      chk1("rb_req_before", dmem_req, 1'b1);
      rst = 1'b1;
      #1;
      chk1("rb_req", dmem_req, 1'b0);
      chk("rb_result", wb_result, 32'h0);
      chk("rb_rd", {27'h0, wb_rd}, 32'h0);
      chk1("rb_regwrite", wb_regwrite, 1'b0);
      chk("rb_addr", dmem_addr, 32'h0);
      chk("rb_be", {28'h0, dmem_be}, 32'h0);
      drive_nop();
      @(negedge clk);
      rst = 1'b0;
      @(posedge clk); #1;
      mem_seq("sw", 32'h40, 32'h1122_3344, 1'b1, 1'b0, 1'b0, 5'd0, 3'b010, 1, 32'h0,
              32'h40, 4'hF, 32'h1122_3344, 1'b1, 32'h40);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- Memory-access stage of the RV32I core; consumes the EX/MEM register outputs of the execute stage.
- Performs byte/half/word loads and stores over a req/ack data-memory bus with variable wait states.
- Stalls upstream while a memory transaction is outstanding.
- Registers the MEM/WB bundle (result, RD, regwrite) for writeback.

Parameters:
- TIMEOUT, 16: max BUSY cycles without dmem_ack before abort (>=2).
- CNT_W, 5: timeout counter width, clog2(TIMEOUT)+1.

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-high reset
- EX_MEM_ALU_OUT  in  32  address for loads/stores; result for non-loads
- EX_MEM_writedata  in  32  store data (rs2)
- EX_MEM_memwrite_en  in  1  store
- EX_MEM_regwrite_en  in  1  instruction writes rd
- EX_MEM_wb_sel  in  1  1 = load (result from memory), 0 = ALU result
- EX_MEM_RD  in  5  destination register
- EX_MEM_funct3  in  3  access size/sign: 000 B, 001 H, 010 W, 100 BU, 101 HU
- dmem_req  out  1  bus request, held until ack
- dmem_we  out  1  1 = write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_be  out  4  byte enables
- dmem_wdata  out  32  lane-replicated store data
- dmem_rdata  in  32  read word, valid with dmem_ack
- dmem_ack  in  1  transaction complete this cycle
- mem_stall  out  1  upstream must hold EX/MEM inputs stable
- MEM_WB_result  out  32  writeback data
- MEM_WB_RD  out  5  writeback register
- MEM_WB_regwrite_en  out  1  writeback enable
- misalign_err  out  1  one-cycle pulse: misaligned or illegal access dropped
- bus_err  out  1  one-cycle pulse: timeout abort

Behaviour:
- Reset: state IDLE; all registered outputs 0; dmem_req = 0; counter = 0. Async: rst mid-BUSY drops dmem_req immediately, no writeback.
- mem_op = EX_MEM_memwrite_en | EX_MEM_wb_sel.
- Legality check:
  - illegal = funct3 in {011, 110, 111}.
  - misaligned = H/HU with addr[0] = 1, or W with addr[1:0] != 0.
- State IDLE:
  - No mem_op: MEM_WB registers load (ALU_OUT, RD, regwrite) at the next edge. Latency 1. mem_stall = 0.
  - mem_op, illegal or misaligned: no bus access. MEM_WB_regwrite_en <= 0, misalign_err <= 1 for one cycle, mem_stall = 0.
  - Legal mem_op: mem_stall = 1 combinationally. Latch addr, we, be, wdata, funct3, RD, regwrite, wb_sel. MEM_WB_regwrite_en <= 0 (bubble). Go to BUSY with counter = 0.
- State BUSY:
  - dmem_req = 1; dmem_we/addr/be/wdata driven from the latched values and constant until ack.
  - mem_stall = !dmem_ack.
  - dmem_ack: MEM_WB_result <= load-extracted data (load) or latched ALU address (store). MEM_WB_RD/regwrite <= latched values. Go to IDLE.
  - No ack with counter = TIMEOUT-1: abort. bus_err pulse, MEM_WB_regwrite_en <= 0, mem_stall = 0 this cycle, go to IDLE.
  - Otherwise counter++.
- Store lanes:
  - SB: be = 4'b0001 << addr[1:0]; wdata = {4{wd[7:0]}}.
  - SH: be = addr[1] ? 1100 : 0011; wdata = {2{wd[15:0]}}.
  - SW: be = 1111; wdata = wd.
- Load extract: select byte/half by addr[1:0]. B/H sign-extend; BU/HU zero-extend; W passes through.
- Loads drive be = 1111 and dmem_we = 0.
- Minimum memory-op latency is 2 cycles (IDLE latch + BUSY with same-cycle ack). One-cycle pulses are registered and clear the following cycle.
- dmem_ack outside BUSY is ignored.

Test Plan:
- ALU op (ALU_OUT = 0x0000_1234, RD = 5, regwrite = 1, wb_sel = 0, memwrite = 0) -> next cycle MEM_WB_result = 0x1234, RD = 5, regwrite = 1; mem_stall never asserted.
- LB at addr 0x103, rdata = 0x80FF_0000, ack 3 cycles after req -> mem_stall high 4 cycles; result = 0xFFFF_FF80. Same access with funct3 = 100 -> result 0x0000_0080.
- SH at addr 0x202, wd = 0x0000_ABCD, ack immediate -> dmem_req one cycle, we = 1, addr = 0x200, be = 1100, wdata = 0xABCD_ABCD; MEM_WB_regwrite_en = 0.
- LW at addr 0x101 -> no dmem_req, misalign_err one-cycle pulse, MEM_WB_regwrite_en = 0, no stall. funct3 = 111 load gives the same response.
- Load, ack never arrives (TIMEOUT = 16) -> dmem_req high exactly 16 cycles, bus_err pulse, stall released, next queued ALU op writes back normally.
- rst asserted in BUSY cycle 2 -> dmem_req low immediately, all outputs 0. After release, a new SW at 0x40 completes normally.
